// File: rtl/left_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : left_shift_sequencer
//  Purpose  : Multi-cycle left shifter. Captures an operand and a shift
//             amount on a start handshake, then shifts left by one bit per
//             enabled clock. Reports the result, the last bit shifted out of
//             the MSB and (arithmetic mode) a sticky signed-overflow flag.
//  Ports    : clk_i       rising-edge clock
//             reset_i     synchronous active-high reset
//             start_i     request, honoured only in IDLE
//             in_i        operand, captured with start
//             amt_i       number of single-bit shifts, captured with start
//             mode_i      0 = arithmetic (overflow tracked), 1 = logical
//             enable_i    0 = pause while shifting, 1 = advance
//             out_o       working register / result
//             busy_o      high in SHIFT and DONE
//             done_o      one-cycle result-valid pulse
//             carry_o     last bit shifted out of the MSB
//             overflow_o  sticky signed overflow (arithmetic mode only)
//  Revision : 1.0 - initial release
// ============================================================================
module left_shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic [AW-1:0]    amt_i,
    input  logic             mode_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [AW-1:0] C_CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q;
    logic [AW-1:0]    cnt_q;
    logic             mode_q;
    logic             carry_q;
    logic             overflow_q;

    // Qualified events shared by the datapath and the next-state logic
    logic w_accept;
    logic w_shift;

    assign w_accept = (state_q == S_IDLE) && start_i;
    assign w_shift  = (state_q == S_SHIFT) && enable_i && (cnt_q != '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // amt = 0 still passes through SHIFT so timing is uniform
                if (start_i) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (enable_i && (cnt_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the registered state only, so no input
    // reaches an output combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_SHIFT: begin
                busy_o = 1'b1;
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (w_accept) begin
            out_q      <= in_i;
            cnt_q      <= amt_i;
            mode_q     <= mode_i;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (w_shift) begin
            out_q   <= out_q << 1;
            carry_q <= out_q[WIDTH-1];
            cnt_q   <= cnt_q - C_CNT_ONE;
            // Sign changes whenever the two top bits differ before the
            // shift; once set the flag stays set for the operation.
            if (!mode_q && (out_q[WIDTH-1] != out_q[WIDTH-2])) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_o      = out_q;
    assign carry_o    = carry_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_left_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_left_shift_sequencer
//  Purpose  : Directed self-checking bench for left_shift_sequencer (WIDTH=16)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_left_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int AW    = 5;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             start_i;
    logic [WIDTH-1:0] in_i;
    logic [AW-1:0]    amt_i;
    logic             mode_i;
    logic             enable_i;
    logic [WIDTH-1:0] out_o;
    logic             busy_o;
    logic             done_o;
    logic             carry_o;
    logic             overflow_o;

    int checks   = 0;
    int failures = 0;

    left_shift_sequencer #(.WIDTH(WIDTH), .AW(AW)) u_dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .in_i       (in_i),
        .amt_i      (amt_i),
        .mode_i     (mode_i),
        .enable_i   (enable_i),
        .out_o      (out_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .carry_o    (carry_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Wait for the done pulse, returning the number of edges taken
    task automatic wait_done(output int n);
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            step();
            n++;
            if (done_o) got = 1'b1;
        end
    endtask

    // One uninterrupted operation with enable held high. Operands are
    // scrambled after capture to show the operation in flight is unaffected.
    task automatic run_op(input string tag, input logic [15:0] din, input logic [4:0] amt,
                          input logic mode, input logic [15:0] exp_out,
                          input logic exp_carry, input logic exp_ovf);
        int n;
        start_i  = 1'b1;
        in_i     = din;
        amt_i    = amt;
        mode_i   = mode;
        enable_i = 1'b1;
        step();
        start_i = 1'b0;
        in_i    = 16'hA5A5;
        amt_i   = 5'd2;
        mode_i  = ~mode;
        check({tag, ".busy"}, 32'(busy_o), 32'd1);
        wait_done(n);
        check({tag, ".lat"},   32'(n),          32'(amt) + 32'd1);
        check({tag, ".out"},   32'(out_o),      32'(exp_out));
        check({tag, ".carry"}, 32'(carry_o),    32'(exp_carry));
        check({tag, ".ovf"},   32'(overflow_o), 32'(exp_ovf));
        step();
        check({tag, ".done_end"}, {31'd0, done_o}, 32'd0);
        check({tag, ".idle"},     {31'd0, busy_o}, 32'd0);
        check({tag, ".hold"},     32'(out_o),      32'(exp_out));
    endtask

    initial begin : main
        int n;
        int done_seen;

        // Reset with random inputs
        reset_i  = 1'b1;
        start_i  = 1'($urandom);
        in_i     = 16'($urandom);
        amt_i    = 5'($urandom);
        mode_i   = 1'($urandom);
        enable_i = 1'($urandom);
        step();
        step();
        check("rst.out",   32'(out_o),      32'd0);
        check("rst.carry", 32'(carry_o),    32'd0);
        check("rst.ovf",   32'(overflow_o), 32'd0);
        check("rst.busy",  32'(busy_o),     32'd0);
        check("rst.done",  32'(done_o),     32'd0);

        // Reset mid-operation aborts without a done pulse
        reset_i  = 1'b0;
        start_i  = 1'b1;
        in_i     = 16'h0003;
        amt_i    = 5'd4;
        mode_i   = 1'b1;
        enable_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        check("abort.shift1", 32'(out_o), 32'h0006);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("abort.out",  32'(out_o),  32'd0);
        check("abort.busy", 32'(busy_o), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_o) done_seen++;
            step();
        end
        check("abort.nodone", 32'(done_seen), 32'd0);

        // Main function
        run_op("logic",   16'h0003, 5'd4,  1'b1, 16'h0030, 1'b0, 1'b0);
        run_op("msb_l",   16'h8001, 5'd1,  1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("msb_a",   16'h8001, 5'd1,  1'b0, 16'h0002, 1'b1, 1'b1);
        run_op("ovf4000", 16'h4000, 5'd1,  1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("noC000",  16'hC000, 5'd1,  1'b0, 16'h8000, 1'b1, 1'b0);
        run_op("sticky",  16'h2000, 5'd3,  1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("amt0",    16'h1234, 5'd0,  1'b0, 16'h1234, 1'b0, 1'b0);
        run_op("amt16",   16'hFFFF, 5'd16, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("amt17",   16'hFFFF, 5'd17, 1'b1, 16'h0000, 1'b0, 1'b0);

        // Pause and ignored starts
        start_i  = 1'b1;
        in_i     = 16'h0001;
        amt_i    = 5'd3;
        mode_i   = 1'b1;
        enable_i = 1'b1;
        step();                         // E0 accept
        in_i = 16'hFFFF;                // start held: ignored while busy
        step();                         // E1 first shift
        start_i  = 1'b0;
        enable_i = 1'b0;
        check("pause.s1", 32'(out_o), 32'h0002);
        step();
        step();
        check("pause.hold", 32'(out_o), 32'h0002);
        check("pause.busy", 32'(busy_o), 32'd1);
        enable_i = 1'b1;
        wait_done(n);
        check("pause.lat", 32'(n) + 32'd3, 32'd6);
        check("pause.out", 32'(out_o), 32'h0008);
        start_i = 1'b1;                 // start during DONE: ignored
        step();
        start_i = 1'b0;
        check("pause.dstart_idle", 32'(busy_o), 32'd0);
        check("pause.dstart_out",  32'(out_o),  32'h0008);
        step();
        check("pause.stay_idle", 32'(busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
